// File: rtl/gate_truth_checker_if.sv
// Bundle between gate_truth_checker and the primitive gate bank / test host.
// The checker side uses the slave modport; the host and gate bank side uses master.
interface gate_truth_checker_if;
  // Handshake: start is a single-cycle request accepted only while the checker
  // is idle (busy=0, done=0); requests at any other time are dropped, never queued.
  // done is a one-cycle completion pulse; pass/fail_mask/truth are valid from
  // that cycle until the next accepted start.
  logic        start;
  logic        a;
  logic        b;
  logic [7:0]  y_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  fail_mask;
  logic [31:0] truth;

  modport master (
    output start, y_in,
    input  a, b, busy, done, pass, fail_mask, truth
  );

  modport slave (
    input  start, y_in,
    output a, b, busy, done, pass, fail_mask, truth
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks the 2-input truth table through the gate bank and records/grades the outputs.
// Optional macro GATE_CHK_ABORT_EN: end the run at the first combo with a mismatch.
module gate_truth_checker #(
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_truth_checker_if.slave  bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  k_q;
  logic [3:0]  cnt_q;
  logic        a_q;
  logic        b_q;
  logic        pass_q;
  logic [7:0]  fail_mask_q;
  logic [31:0] truth_q;
  logic [7:0]  expected;
  logic [7:0]  mismatch;
  logic        end_run;

  // Golden gate vector for the combo currently on a/b, bit order matches y_in.
  always_comb begin
    expected    = 8'h00;
    expected[0] = a_q & b_q;
    expected[1] = a_q | b_q;
    expected[2] = ~a_q;
    expected[3] = ~(a_q & b_q);
    expected[4] = ~(a_q | b_q);
    expected[5] = a_q;
    expected[6] = a_q ^ b_q;
    expected[7] = ~(a_q ^ b_q);
    mismatch    = bus.y_in ^ expected;
  end

`ifdef GATE_CHK_ABORT_EN
  assign end_run = (k_q == 2'd3) || (mismatch != 8'h00);
`else
  assign end_run = (k_q == 2'd3);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE:   if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = end_run ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 8'h00;
      truth_q     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            k_q         <= 2'd0;
            cnt_q       <= 4'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 8'h00;
            truth_q     <= 32'h0;
          end
        end
        DRIVE: cnt_q <= cnt_q + 4'd1;
        SAMPLE: begin
          truth_q[{k_q, 3'b000} +: 8] <= bus.y_in;
          fail_mask_q                 <= fail_mask_q | mismatch;
          if (end_run) begin
            pass_q <= ~|(fail_mask_q | mismatch);
          end else begin
            // a is the MSB of the combo index, so the next combo is simply k+1.
            k_q          <= k_q + 2'd1;
            {a_q, b_q}   <= k_q + 2'd1;
            cnt_q        <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.truth     = truth_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE=1 and SETTLE=3) share a modelled gate bank
// with injectable stuck-at and per-combo flip faults; results are graded against a spec model.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_truth_checker_if if1();
  gate_truth_checker_if if3();
  logic [1:0] dbg1;
  logic [1:0] dbg3;

  gate_truth_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state(dbg1));
  gate_truth_checker #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .dbg_state(dbg3));

  int checks = 0;
  int failures = 0;

  logic [7:0]  stuck0;
  logic [7:0]  stuck1;
  logic [31:0] flips;

  // Gate vector straight from the boolean definitions, using integer arithmetic.
  function automatic logic [7:0] ref_vec(input int k);
    int a;
    int b;
    logic [7:0] v;
    a = k / 2;
    b = k % 2;
    v[0] = (a * b) == 1;
    v[1] = (a + b) > 0;
    v[2] = a == 0;
    v[3] = (a * b) == 0;
    v[4] = (a + b) == 0;
    v[5] = a == 1;
    v[6] = (a + b) == 1;
    v[7] = (a + b) != 1;
    return v;
  endfunction

  function automatic logic [7:0] bank(input int k, input logic [7:0] s0, input logic [7:0] s1,
                                      input logic [31:0] fl);
    return ((ref_vec(k) & ~s0) | s1) ^ fl[8*k +: 8];
  endfunction

  always_comb if1.y_in = bank(int'({if1.a, if1.b}), stuck0, stuck1, flips);
  always_comb if3.y_in = bank(int'({if3.a, if3.b}), stuck0, stuck1, flips);

  int          cur_sel;
  logic        o_a, o_b, o_busy, o_done, o_pass;
  logic [7:0]  o_fail;
  logic [31:0] o_truth;
  logic [1:0]  o_state;

  always_comb begin
    o_a     = (cur_sel == 1) ? if3.a         : if1.a;
    o_b     = (cur_sel == 1) ? if3.b         : if1.b;
    o_busy  = (cur_sel == 1) ? if3.busy      : if1.busy;
    o_done  = (cur_sel == 1) ? if3.done      : if1.done;
    o_pass  = (cur_sel == 1) ? if3.pass      : if1.pass;
    o_fail  = (cur_sel == 1) ? if3.fail_mask : if1.fail_mask;
    o_truth = (cur_sel == 1) ? if3.truth     : if1.truth;
    o_state = (cur_sel == 1) ? dbg3          : dbg1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur_sel == 1) if3.start = v;
    else              if1.start = v;
  endtask

  // Spec model of one run with the current fault setting.
  task automatic model(input int s, output logic [31:0] t, output logic [7:0] fm,
                       output logic p, output int lat);
    logic [7:0] obs;
    logic [7:0] mm;
    bit stop;
    t = 32'h0; fm = 8'h00; lat = 4 * (s + 1); stop = 0;
    for (int k = 0; k < 4; k++) begin
      if (!stop) begin
        obs = bank(k, stuck0, stuck1, flips);
        mm  = obs ^ ref_vec(k);
        t[8*k +: 8] = obs;
        fm = fm | mm;
`ifdef GATE_CHK_ABORT_EN
        if (mm != 8'h00) begin
          lat  = (k + 1) * (s + 1);
          stop = 1;
        end
`endif
      end
    end
    p = (fm == 8'h00);
  endtask

  logic [31:0] last_truth;
  logic [7:0]  last_fail;
  logic        last_pass;
  int          last_lat;

  task automatic run_check(input int sel, input bit poke, input string tag);
    int s;
    int n;
    int lat;
    logic [31:0] et;
    logic [7:0]  ef;
    logic        ep;
    cur_sel = sel;
    s = (sel == 1) ? 3 : 1;
    model(s, et, ef, ep, lat);
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1; set_start(1'b0);
    n = 0;
    while (!o_done && n < 200) begin
      check({tag, "_ab"}, {30'd0, o_a, o_b}, 32'(n / (s + 1)));
      check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
      @(posedge clk); #1;
      n++;
      if (poke && n == 2) set_start(1'b1);
      if (poke && n == 3) set_start(1'b0);
    end
    last_lat = n;
    last_truth = o_truth; last_fail = o_fail; last_pass = o_pass;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_done"}, {31'd0, o_done}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_truth"}, o_truth, et);
    check({tag, "_fail_mask"}, {24'd0, o_fail}, {24'd0, ef});
    check({tag, "_pass"}, {31'd0, o_pass}, {31'd0, ep});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    check({tag, "_idle"}, {30'd0, o_state}, 32'd0);
    check({tag, "_hold_truth"}, o_truth, et);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_b"}, {30'd0, o_a, o_b}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check({tag, "_pass"}, {31'd0, o_pass}, 32'd0);
    check({tag, "_fail_mask"}, {24'd0, o_fail}, 32'd0);
    check({tag, "_truth"}, o_truth, 32'd0);
    check({tag, "_state"}, {30'd0, o_state}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] et;
    logic [7:0]  ef;
    logic        ep;
    int          lat;
    rst_n = 1'b0; if1.start = 1'b0; if3.start = 1'b0;
    stuck0 = 8'h00; stuck1 = 8'h00; flips = 32'h0; cur_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset1");
    cur_sel = 1; #1;
    check_reset_vals("reset3");
    @(negedge clk) rst_n = 1'b1;

    // Clean bank, SETTLE=1.
    run_check(0, 0, "clean1");
    check("clean1_const_truth", last_truth, 32'hA36A4E9C);
    check("clean1_const_lat", 32'(last_lat), 32'd8);

`ifndef GATE_CHK_ABORT_EN
    // xor output stuck at 0.
    stuck0 = 8'h40;
    run_check(0, 0, "xor0");
    check("xor0_const_truth", last_truth, 32'hA32A0E9C);
    check("xor0_const_fail", {24'd0, last_fail}, 32'h40);
    stuck0 = 8'h00;
`else
    // and output stuck at 1 aborts on combo 0.
    stuck1 = 8'h01;
    run_check(0, 0, "abort");
    check("abort_const_truth", last_truth, 32'h0000009D);
    check("abort_const_fail", {24'd0, last_fail}, 32'h01);
    check("abort_const_lat", 32'(last_lat), 32'd2);
    stuck1 = 8'h00;
`endif

    // Reset pulsed during SAMPLE of combo 2.
    cur_sel = 0;
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_in_sample", {30'd0, o_state}, 32'd2);
    check("midrst_ab", {30'd0, o_a, o_b}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk) rst_n = 1'b1;
    run_check(0, 0, "after_rst");
    check("after_rst_const_truth", last_truth, 32'hA36A4E9C);

    // SETTLE=3 with a start poke while busy.
    run_check(1, 1, "settle3");
    check("settle3_const_lat", 32'(last_lat), 32'd16);

    // start held high: done every 10 cycles, same results each run.
    cur_sel = 0;
    model(1, et, ef, ep, lat);
    @(negedge clk); if1.start = 1'b1;
    n = 0;
    while (!o_done && n < 100) begin @(posedge clk); #1; n++; end
    check("held_first_done", {31'd0, o_done}, 32'd1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!o_done && n < 100);
      check("held_period", 32'(n), 32'd10);
      check("held_truth", o_truth, et);
      check("held_pass", {31'd0, o_pass}, {31'd0, ep});
    end
    @(negedge clk); if1.start = 1'b0;
    repeat (2) @(posedge clk);

    // Random fault patterns on both instances.
    for (int i = 0; i < 10; i++) begin
      stuck0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      stuck1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      for (int k = 0; k < 4; k++)
        flips[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      run_check($urandom_range(0, 1), 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Sequential stimulus-and-check stage wrapped around the primitive gate library. On a start pulse it walks the two-input truth table by driving shared `a`/`b` into the eight gate instances (and, or, not, nand, nor, buffer, xor, xnor). It samples their `y` outputs after a settle delay and records the observed table. It then reports pass/fail per gate. It is the upstream driver and downstream consumer of the gate bank, used for bring-up and self-test.

## Interface
Parameters:
- `SETTLE`, 1: cycles `a`/`b` are held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; honoured only in IDLE.
- `a`  out  1  gate input A, registered; also drives not/buffer.
- `b`  out  1  gate input B, registered.
- `y_in`  in  8  gate outputs: [0] and, [1] or, [2] not, [3] nand, [4] nor, [5] buffer, [6] xor, [7] xnor.
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  held; 1 if the last run had no mismatch.
- `fail_mask`  out  8  held; bit i set if gate i mismatched on any combo.
- `truth`  out  32  held observed table; combo k occupies [8k+7:8k].

## Operation
- Combo index k (2 bits), {a,b} = k, with a as MSB: 00, 01, 10, 11.
- Expected vector per combo: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), buffer=a, xor=a^b, xnor=~(a^b).
- FSM states:
  - IDLE: if `start`, go to DRIVE and set k=0, {a,b}=00, settle counter=0. Clear `truth`, `fail_mask` and `pass`.
  - DRIVE: settle counter increments each edge; at count SETTLE-1, go to SAMPLE.
  - SAMPLE: write `y_in` into `truth` slot k and OR (`y_in` ^ expected) into `fail_mask`.
    - If k==3, go to DONE and set `pass` = no bit set in (`fail_mask` | current mismatch).
    - Otherwise k++, drive the next {a,b}, clear the counter, and go to DRIVE.
  - DONE: `done`=1 for this single cycle, then go to IDLE unconditionally.
- `start` is ignored in DRIVE, SAMPLE and DONE; there is no queueing.
- Reset values (asynchronous, all registers): state=IDLE; `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `truth`=0, k=0, counter=0.
- Reset asserted mid-run: all outputs return to reset values immediately, and the partial table is discarded.
- `y_in` is treated as asynchronous-settled combinational data. It is sampled only in SAMPLE; its value in other states is don't-care.

## Timing
- Each combo takes SETTLE cycles in DRIVE plus 1 cycle in SAMPLE.
- `done` is high in the cycle following edge 4·(SETTLE+1) counted from the edge that accepted `start`. For SETTLE=1 that is 8 edges.
- `a`/`b` change only on the edge leaving SAMPLE (or leaving IDLE). They are stable for exactly SETTLE+1 cycles per combo.
- `pass`, `fail_mask` and `truth` are final in the same cycle `done` is high, and hold until the next accepted `start`.
- Back-to-back runs with `start` held high: DONE, then one IDLE cycle, then restart; the period is 4·(SETTLE+1)+2 cycles.

## Configuration
- `GATE_CHK_ABORT_EN`, when defined: a SAMPLE with any mismatch goes straight to DONE.
  - `pass`=0 and `fail_mask` holds that combo's mismatches.
  - Later `truth` slots stay 0.
  - `done` fires (k+1)·(SETTLE+1) edges after start, where k is the failing combo.
- When not defined: all four combos always run, and the abort logic is absent.

## Test plan
- Correct gates, SETTLE=1, pulse `start` → `done` 8 edges later; `pass`=1, `fail_mask`=8'h00, `truth`=32'hA36A4E9C.
- xor output (`y_in[6]`) forced 0 → `pass`=0, `fail_mask`=8'h40, `truth`=32'hA32A0E9C.
- `rst_n` pulsed low during SAMPLE of combo 2 → all outputs 0 immediately; the next `start` completes normally with `truth`=32'hA36A4E9C.
- SETTLE=3, correct gates → each {a,b} held 4 cycles; `done` 16 edges after start; `start` pulsed while `busy`=1 has no effect.
- `start` held high, SETTLE=1 → `done` pulses every 10 cycles, and results are identical each run.
- With `GATE_CHK_ABORT_EN` defined, `y_in[0]` stuck at 1 → `done` 2 edges after start; `fail_mask`=8'h01, `truth`=32'h0000009D, `pass`=0.
